// File: rtl/sample_uart_streamer.sv
// N-channel sample snapshot streamer: sync-framed 8N1 UART dump of decimated sample frames.
// Optional trailing XOR checksum byte when SAMPLE_UART_CHECKSUM_EN is defined.
module sample_uart_streamer #(
  parameter int          W            = 16,
  parameter int          N_CH         = 4,
  parameter int          CLKS_PER_BIT = 12,
  parameter int          DECIMATE     = 1,
  parameter logic [15:0] SYNC         = 16'hA55A
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_clk,
  input  logic [N_CH*W-1:0] in_flat,
  input  logic              enable,
  output logic              tx_o,
  output logic              busy,
  output logic [7:0]        drop_cnt
);

  localparam int DATA_BYTES = (N_CH * W) / 8;
`ifdef SAMPLE_UART_CHECKSUM_EN
  localparam int FRAME_BYTES = 3 + DATA_BYTES;
`else
  localparam int FRAME_BYTES = 2 + DATA_BYTES;
`endif
  localparam int          SHW      = 16 + N_CH * W;
  localparam int          TW       = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] BIT_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [15:0] DEC_LAST = 16'(DECIMATE - 1);
  localparam logic [7:0]  BYTES_AFTER_FIRST = 8'(FRAME_BYTES - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_r;
  logic            sample_clk_q_r;
  logic [15:0]     decim_r;
  logic [TW-1:0]   timer_r;
  logic [2:0]      bit_idx_r;
  logic [7:0]      bytes_left_r;
  logic [7:0]      tx_byte_r;
  logic [SHW-1:0]  shift_r;
`ifdef SAMPLE_UART_CHECKSUM_EN
  logic [7:0]      csum_r;
`endif

  logic            ev_s;
  logic            kept_s;
  logic [SHW-1:0]  frame_s;
  logic [7:0]      next_byte_s;

  assign ev_s   = sample_clk & ~sample_clk_q_r;
  assign kept_s = ev_s & enable & (decim_r == 16'd0);

  // Frame image in transmit order: SYNC on top, then ch0 down to ch(N_CH-1).
  always_comb begin
    frame_s = '0;
    frame_s[SHW-1 -: 16] = SYNC;
    for (int k = 0; k < N_CH; k++) begin
      frame_s[SHW-17-k*W -: W] = in_flat[k*W +: W];
    end
  end

  // Byte to load when a stop bit ends and more bytes remain.
  always_comb begin
    next_byte_s = shift_r[SHW-1 -: 8];
`ifdef SAMPLE_UART_CHECKSUM_EN
    if (bytes_left_r == 8'd1) begin
      next_byte_s = csum_r;
    end else begin
      next_byte_s = shift_r[SHW-1 -: 8];
    end
`endif
  end

  // Edge detector on the sample strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_clk_q_r <= 1'b0;
    end else begin
      sample_clk_q_r <= sample_clk;
    end
  end

  // Decimation counter; frozen while enable is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      decim_r <= 16'd0;
    end else if (ev_s && enable) begin
      decim_r <= (decim_r == DEC_LAST) ? 16'd0 : decim_r + 16'd1;
    end
  end

  // Saturating count of kept frames that arrived while a frame was in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= 8'd0;
    end else if (kept_s && busy && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end

  // Byte/bit FSM; tx_o and busy are registered here so the start bit begins the cycle after ev.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      tx_o         <= 1'b1;
      busy         <= 1'b0;
      timer_r      <= '0;
      bit_idx_r    <= 3'd0;
      bytes_left_r <= 8'd0;
      tx_byte_r    <= 8'd0;
      shift_r      <= '0;
`ifdef SAMPLE_UART_CHECKSUM_EN
      csum_r       <= 8'd0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          tx_o <= 1'b1;
          busy <= 1'b0;
          if (kept_s) begin
            state_r      <= START;
            tx_o         <= 1'b0;
            busy         <= 1'b1;
            timer_r      <= BIT_LAST;
            tx_byte_r    <= frame_s[SHW-1 -: 8];
            shift_r      <= {frame_s[SHW-9:0], 8'h00};
            bytes_left_r <= BYTES_AFTER_FIRST;
`ifdef SAMPLE_UART_CHECKSUM_EN
            csum_r       <= frame_s[SHW-1 -: 8];
`endif
          end
        end
        START: begin
          if (timer_r == '0) begin
            state_r   <= DATA;
            timer_r   <= BIT_LAST;
            bit_idx_r <= 3'd0;
            tx_o      <= tx_byte_r[0];
            tx_byte_r <= {1'b0, tx_byte_r[7:1]};
          end else begin
            timer_r <= timer_r - 1'b1;
          end
        end
        DATA: begin
          if (timer_r == '0) begin
            timer_r <= BIT_LAST;
            if (bit_idx_r == 3'd7) begin
              state_r <= STOP;
              tx_o    <= 1'b1;
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
              tx_o      <= tx_byte_r[0];
              tx_byte_r <= {1'b0, tx_byte_r[7:1]};
            end
          end else begin
            timer_r <= timer_r - 1'b1;
          end
        end
        STOP: begin
          if (timer_r == '0) begin
            if (bytes_left_r != 8'd0) begin
              state_r      <= START;
              tx_o         <= 1'b0;
              timer_r      <= BIT_LAST;
              tx_byte_r    <= next_byte_s;
              shift_r      <= {shift_r[SHW-9:0], 8'h00};
              bytes_left_r <= bytes_left_r - 8'd1;
`ifdef SAMPLE_UART_CHECKSUM_EN
              csum_r       <= csum_r ^ next_byte_s;
`endif
            end else begin
              state_r <= IDLE;
              busy    <= 1'b0;
            end
          end else begin
            timer_r <= timer_r - 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
          tx_o    <= 1'b1;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
